// File: rtl/vproc_pkg.sv
// Shared vector-processor types used by the divide sequencer.
// Element-width helpers keep width decoding in one place.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'd0,
    VSEW_16      = 2'd1,
    VSEW_32      = 2'd2,
    VSEW_INVALID = 2'd3
  } vsew_t;

  typedef enum logic [1:0] {
    DIV_OP_DIVU = 2'd0,
    DIV_OP_DIV  = 2'd1,
    DIV_OP_REMU = 2'd2,
    DIV_OP_REM  = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    DIV_SEQ_IDLE  = 3'd0,
    DIV_SEQ_PREP  = 3'd1,
    DIV_SEQ_ITER  = 3'd2,
    DIV_SEQ_FIXUP = 3'd3,
    DIV_SEQ_DONE  = 3'd4
  } div_seq_state_t;

  localparam int unsigned DIV_OP_W = 32;

  // Mask covering the low W bits of an element.
  function automatic logic [31:0] eew_mask(vsew_t eew);
    case (eew)
      VSEW_8:  return 32'h0000_00FF;
      VSEW_16: return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Index of the element sign bit, W-1; doubles as the iteration count seed.
  function automatic logic [4:0] eew_msb(vsew_t eew);
    case (eew)
      VSEW_8:  return 5'd7;
      VSEW_16: return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/vproc_div_seq_if.sv
// Element handshake bundle between the DIV operand buffers, the sequencer
// and the result buffer.
interface vproc_div_seq_if #(
  parameter type         CTRL_T   = logic,
  parameter int unsigned DIV_OP_W = 32
);
  import vproc_pkg::*;

  logic                pipe_in_valid_i;
  logic                pipe_in_ready_o;
  CTRL_T               pipe_in_ctrl_i;
  vsew_t               pipe_in_eew_i;
  div_op_t             pipe_in_op_i;
  logic [DIV_OP_W-1:0] pipe_in_op1_i;
  logic [DIV_OP_W-1:0] pipe_in_op2_i;
  logic                pipe_in_mask_i;
  logic                pipe_out_valid_o;
  logic                pipe_out_ready_i;
  CTRL_T               pipe_out_ctrl_o;
  logic [DIV_OP_W-1:0] pipe_out_res_o;
  logic                pipe_out_mask_o;

  modport master (
    output pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_eew_i, pipe_in_op_i,
           pipe_in_op1_i, pipe_in_op2_i, pipe_in_mask_i, pipe_out_ready_i,
    input  pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o,
           pipe_out_res_o, pipe_out_mask_o
  );

  modport slave (
    input  pipe_in_valid_i, pipe_in_ctrl_i, pipe_in_eew_i, pipe_in_op_i,
           pipe_in_op1_i, pipe_in_op2_i, pipe_in_mask_i, pipe_out_ready_i,
    output pipe_in_ready_o, pipe_out_valid_o, pipe_out_ctrl_o,
           pipe_out_res_o, pipe_out_mask_o
  );

endinterface

// File: rtl/vproc_div_iter_step.sv
// One radix-2 restoring divide step: shift in the next dividend bit and
// subtract the divisor, keeping the shifted value if the subtract underflows.
module vproc_div_iter_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] div_i,
  input  logic        bit_i,
  output logic [32:0] rem_o,
  output logic        q_o
);

  logic [33:0] shifted;
  logic [33:0] diff;

  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, div_i};
    q_o     = ~diff[33];
    rem_o   = q_o ? diff[32:0] : shifted[32:0];
  end

endmodule

// File: rtl/vproc_div_seq.sv
// Multi-cycle integer divide sequencer for one vector lane (8/16/32-bit
// elements), with RISC-V divide-by-zero and signed-overflow results.
module vproc_div_seq
  import vproc_pkg::*;
#(
  parameter int unsigned DIV_OP_W = 32,
  parameter type         CTRL_T   = logic
) (
  input  logic            clk_i,
  input  logic            async_rst_ni,
  vproc_div_seq_if.slave  pipe
);

  div_seq_state_t state_q, state_d;
  CTRL_T          ctrl_q, ctrl_d;
  vsew_t          eew_q, eew_d;
  div_op_t        op_q, op_d;
  logic           mask_q, mask_d;
  logic [31:0]    a_q, a_d;       // raw dividend, then dividend/quotient shift reg
  logic [31:0]    b_q, b_d;       // raw divisor, then |divisor|
  logic [32:0]    rem_q, rem_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic [31:0]    res_q, res_d;

  logic        in_ready, accept;
  logic [31:0] wmask, op1_w, op2_w, op1_x, op2_x, abs1, abs2, quo, q_fix, r_fix;
  logic [4:0]  msb;
  logic        is_signed, is_div, sign1, sign2, div_zero, ovf;
  logic [32:0] step_rem;
  logic        step_q;

  vproc_div_iter_step u_step (
    .rem_i (rem_q),
    .div_i (b_q),
    .bit_i (a_q[31]),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    in_ready  = (state_q == DIV_SEQ_IDLE) |
                ((state_q == DIV_SEQ_DONE) & pipe.pipe_out_ready_i);
    accept    = pipe.pipe_in_valid_i & in_ready;

    wmask     = eew_mask(eew_q);
    msb       = eew_msb(eew_q);
    is_signed = (op_q == DIV_OP_DIV) | (op_q == DIV_OP_REM);
    is_div    = (op_q == DIV_OP_DIV) | (op_q == DIV_OP_DIVU);
    op1_w     = a_q & wmask;
    op2_w     = b_q & wmask;
    sign1     = is_signed & a_q[msb];
    sign2     = is_signed & b_q[msb];
    op1_x     = sign1 ? (op1_w | ~wmask) : op1_w;
    op2_x     = sign2 ? (op2_w | ~wmask) : op2_w;
    abs1      = sign1 ? (~op1_x + 32'd1) : op1_x;
    abs2      = sign2 ? (~op2_x + 32'd1) : op2_x;
    div_zero  = (op2_w == 32'd0);
    ovf       = is_signed & (op1_w == (wmask & ~(wmask >> 1))) & (op2_w == wmask);

    quo       = a_q & wmask;
    q_fix     = qneg_q ? (~quo + 32'd1) : quo;
    r_fix     = rneg_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];

    state_d = state_q;
    ctrl_d  = ctrl_q;
    eew_d   = eew_q;
    op_d    = op_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;

    case (state_q)
      DIV_SEQ_IDLE: ;
      DIV_SEQ_PREP: begin
        state_d = DIV_SEQ_DONE;
        if (!mask_q) begin
          res_d = 32'd0;
        end else if (div_zero) begin
          res_d = is_div ? wmask : op1_w;
        end else if (ovf) begin
          res_d = is_div ? op1_w : 32'd0;
        end else begin
          // Left-align |dividend| so its MSB is always shifted out of bit 31.
          a_d     = abs1 << (5'd31 - msb);
          b_d     = abs2;
          rem_d   = 33'd0;
          qneg_d  = sign1 ^ sign2;
          rneg_d  = sign1;
          cnt_d   = msb;
          state_d = DIV_SEQ_ITER;
        end
      end
      DIV_SEQ_ITER: begin
        a_d   = {a_q[30:0], step_q};
        rem_d = step_rem;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = DIV_SEQ_FIXUP;
      end
      DIV_SEQ_FIXUP: begin
        res_d   = (is_div ? q_fix : r_fix) & wmask;
        state_d = DIV_SEQ_DONE;
      end
      DIV_SEQ_DONE: begin
        if (pipe.pipe_out_ready_i) state_d = DIV_SEQ_IDLE;
      end
      default: state_d = DIV_SEQ_IDLE;
    endcase

    // Result hand-off and new acceptance share a cycle; acceptance wins.
    if (accept) begin
      ctrl_d  = pipe.pipe_in_ctrl_i;
      eew_d   = pipe.pipe_in_eew_i;
      op_d    = pipe.pipe_in_op_i;
      mask_d  = pipe.pipe_in_mask_i;
      a_d     = pipe.pipe_in_op1_i;
      b_d     = pipe.pipe_in_op2_i;
      state_d = DIV_SEQ_PREP;
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q <= DIV_SEQ_IDLE;
      ctrl_q  <= '0;
      eew_q   <= VSEW_8;
      op_q    <= DIV_OP_DIVU;
      mask_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      eew_q   <= eew_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign pipe.pipe_in_ready_o  = in_ready;
  assign pipe.pipe_out_valid_o = (state_q == DIV_SEQ_DONE);
  assign pipe.pipe_out_ctrl_o  = ctrl_q;
  assign pipe.pipe_out_res_o   = res_q;
  assign pipe.pipe_out_mask_o  = mask_q;

endmodule

// File: tb/tb_vproc_div_seq.sv
// Directed plus randomized checks of vproc_div_seq against an arithmetic
// reference model of RISC-V element division.
module tb_vproc_div_seq;
  import vproc_pkg::*;

  typedef logic [3:0] ctrl_t;

  logic clk_i;
  logic async_rst_ni;
  int   errors = 0;
  int   checks = 0;

  vproc_div_seq_if #(.CTRL_T(ctrl_t), .DIV_OP_W(32)) ifc ();

  vproc_div_seq #(.DIV_OP_W(32), .CTRL_T(ctrl_t)) dut (
    .clk_i        (clk_i),
    .async_rst_ni (async_rst_ni),
    .pipe         (ifc.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the W-bit element values.
  task automatic ref_model(input div_op_t op, input vsew_t eew, input logic [31:0] a,
                           input logic [31:0] b, input logic m,
                           output logic [31:0] res, output int lat);
    longint one = 1;
    longint w, span, x, y, r;
    bit sgn, isdiv;
    w     = 8 << int'(eew);
    span  = one << w;
    x     = longint'(a) & (span - 1);
    y     = longint'(b) & (span - 1);
    sgn   = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    isdiv = (op == DIV_OP_DIV) || (op == DIV_OP_DIVU);
    if (sgn && x >= span / 2) x -= span;
    if (sgn && y >= span / 2) y -= span;
    lat = 2;
    if (!m)                                   r = 0;
    else if (y == 0)                          r = isdiv ? span - 1 : x;
    else if (sgn && x == -span / 2 && y == -1) r = isdiv ? x : 0;
    else begin
      r   = isdiv ? x / y : x % y;
      lat = int'(w) + 3;
    end
    res = 32'(r & (span - 1));
  endtask

  task automatic drive(input div_op_t op, input vsew_t eew, input logic [31:0] a,
                       input logic [31:0] b, input logic m, input ctrl_t c);
    ifc.pipe_in_op_i    = op;
    ifc.pipe_in_eew_i   = eew;
    ifc.pipe_in_op1_i   = a;
    ifc.pipe_in_op2_i   = b;
    ifc.pipe_in_mask_i  = m;
    ifc.pipe_in_ctrl_i  = c;
    ifc.pipe_in_valid_i = 1'b1;
  endtask

  // Called at a negedge with inputs driven; returns #1 after the acceptance edge.
  task automatic wait_accept(input string tag);
    int n = 0;
    #1;
    while (!ifc.pipe_in_ready_o && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    chk({tag, "_accept_to"}, 32'(n < 200), 32'd1);
    @(posedge clk_i); #1;
    ifc.pipe_in_valid_i = 1'b0;
  endtask

  // Entered in cycle c+1; lat reports the cycle offset where valid first rises.
  task automatic wait_result(input string tag, input logic [31:0] exp_res, input int exp_lat,
                             input logic exp_mask, input ctrl_t exp_ctrl);
    int lat = 1;
    while (!ifc.pipe_out_valid_o && lat < 100) begin
      @(posedge clk_i); #1; lat++;
    end
    chk({tag, "_lat"},  32'(lat), 32'(exp_lat));
    chk({tag, "_res"},  ifc.pipe_out_res_o, exp_res);
    chk({tag, "_mask"}, 32'(ifc.pipe_out_mask_o), 32'(exp_mask));
    chk({tag, "_ctrl"}, 32'(ifc.pipe_out_ctrl_o), 32'(exp_ctrl));
  endtask

  task automatic pop(input string tag);
    @(negedge clk_i);
    ifc.pipe_out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    ifc.pipe_out_ready_i = 1'b0;
    chk({tag, "_drained"}, 32'(ifc.pipe_out_valid_o), 32'd0);
  endtask

  task automatic run_one(input string tag, input div_op_t op, input vsew_t eew,
                         input logic [31:0] a, input logic [31:0] b, input logic m,
                         input ctrl_t c, input logic [31:0] exp_res, input int exp_lat);
    @(negedge clk_i);
    drive(op, eew, a, b, m, c);
    wait_accept(tag);
    wait_result(tag, exp_res, exp_lat, m, c);
    pop(tag);
  endtask

  initial begin
    logic [31:0] er, a, b;
    int          el;
    div_op_t     op;
    vsew_t       eew;
    logic        m;
    ctrl_t       c;

    async_rst_ni         = 1'b0;
    ifc.pipe_in_valid_i  = 1'b0;
    ifc.pipe_in_ctrl_i   = '0;
    ifc.pipe_in_eew_i    = VSEW_8;
    ifc.pipe_in_op_i     = DIV_OP_DIVU;
    ifc.pipe_in_op1_i    = '0;
    ifc.pipe_in_op2_i    = '0;
    ifc.pipe_in_mask_i   = 1'b0;
    ifc.pipe_out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(ifc.pipe_out_valid_o), 32'd0);
    chk("rst_res",   ifc.pipe_out_res_o, 32'd0);
    chk("rst_mask",  32'(ifc.pipe_out_mask_o), 32'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    #1;
    chk("rst_ready", 32'(ifc.pipe_in_ready_o), 32'd1);

    // Directed cases with hand-derived results.
    run_one("divu8",     DIV_OP_DIVU, VSEW_8,  32'd200,      32'd7,      1'b1, 4'h3, 32'h0000_001C, 11);
    run_one("rem32",     DIV_OP_REM,  VSEW_32, 32'hFFFF_FFF9, 32'd2,      1'b1, 4'h5, 32'hFFFF_FFFF, 35);
    run_one("div32",     DIV_OP_DIV,  VSEW_32, 32'hFFFF_FFF9, 32'd2,      1'b1, 4'h6, 32'hFFFF_FFFD, 35);
    run_one("div16_ovf", DIV_OP_DIV,  VSEW_16, 32'h0000_8000, 32'h0000_FFFF, 1'b1, 4'h7, 32'h0000_8000, 2);
    run_one("rem16_ovf", DIV_OP_REM,  VSEW_16, 32'h0000_8000, 32'h0000_FFFF, 1'b1, 4'h8, 32'h0000_0000, 2);
    run_one("divu32_z",  DIV_OP_DIVU, VSEW_32, 32'h1234_5678, 32'd0,      1'b1, 4'h9, 32'hFFFF_FFFF, 2);
    run_one("remu8_z",   DIV_OP_REMU, VSEW_8,  32'h0000_005A, 32'd0,      1'b1, 4'hA, 32'h0000_005A, 2);
    run_one("masked",    DIV_OP_DIV,  VSEW_16, 32'h0000_1234, 32'd5,      1'b0, 4'hB, 32'h0000_0000, 2);
    run_one("rem8_neg",  DIV_OP_REM,  VSEW_8,  32'hFFFF_FF9C, 32'h0000_00F9, 1'b1, 4'hC, 32'h0000_00FE, 11);

    // Backpressure: result must hold while ready stays low.
    @(negedge clk_i);
    drive(DIV_OP_DIVU, VSEW_8, 32'd100, 32'd9, 1'b1, 4'h1);
    wait_accept("bp");
    wait_result("bp", 32'd11, 11, 1'b1, 4'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      chk("bp_hold_valid", 32'(ifc.pipe_out_valid_o), 32'd1);
      chk("bp_hold_res",   ifc.pipe_out_res_o, 32'd11);
      chk("bp_in_ready",   32'(ifc.pipe_in_ready_o), 32'd0);
    end
    // Back-to-back: result leaves and next element enters on the same edge.
    @(negedge clk_i);
    drive(DIV_OP_DIVU, VSEW_16, 32'd1000, 32'd10, 1'b1, 4'h2);
    ifc.pipe_out_ready_i = 1'b1;
    #1;
    chk("b2b_in_ready",  32'(ifc.pipe_in_ready_o), 32'd1);
    chk("b2b_out_valid", 32'(ifc.pipe_out_valid_o), 32'd1);
    @(posedge clk_i); #1;
    ifc.pipe_in_valid_i  = 1'b0;
    ifc.pipe_out_ready_i = 1'b0;
    chk("b2b_prep_valid", 32'(ifc.pipe_out_valid_o), 32'd0);
    wait_result("b2b", 32'd100, 19, 1'b1, 4'h2);
    pop("b2b");

    // Reset while iterating, then while a result is waiting.
    @(negedge clk_i);
    drive(DIV_OP_DIVU, VSEW_32, 32'hFFFF_FFF0, 32'd3, 1'b1, 4'hD);
    wait_accept("rst_iter");
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    async_rst_ni = 1'b0;
    #1;
    chk("rst_iter_valid", 32'(ifc.pipe_out_valid_o), 32'd0);
    chk("rst_iter_res",   ifc.pipe_out_res_o, 32'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;
    #1;
    chk("rst_iter_ready", 32'(ifc.pipe_in_ready_o), 32'd1);
    run_one("post_rst", DIV_OP_DIVU, VSEW_8, 32'd9, 32'd3, 1'b1, 4'hE, 32'd3, 11);

    @(negedge clk_i);
    drive(DIV_OP_DIVU, VSEW_8, 32'd50, 32'd0, 1'b1, 4'h4);
    wait_accept("rst_done");
    wait_result("rst_done", 32'h0000_00FF, 2, 1'b1, 4'h4);
    @(negedge clk_i);
    async_rst_ni = 1'b0;
    #1;
    chk("rst_done_valid", 32'(ifc.pipe_out_valid_o), 32'd0);
    chk("rst_done_res",   ifc.pipe_out_res_o, 32'd0);
    @(negedge clk_i);
    async_rst_ni = 1'b1;

    // Randomized elements against the reference model.
    for (int i = 0; i < 40; i++) begin
      op  = div_op_t'($urandom_range(0, 3));
      eew = vsew_t'($urandom_range(0, 2));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 15);
        default: b = $urandom >> $urandom_range(0, 28);
      endcase
      if ($urandom_range(0, 7) == 0) a = (eew == VSEW_8) ? 32'h80 : (eew == VSEW_16) ? 32'h8000 : 32'h8000_0000;
      m = ($urandom_range(0, 9) != 0);
      c = 4'($urandom);
      ref_model(op, eew, a, b, m, er, el);
      @(negedge clk_i);
      drive(op, eew, a, b, m, c);
      wait_accept("rnd");
      wait_result("rnd", er, el, m, c);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_i); #1;
        chk("rnd_hold", ifc.pipe_out_res_o, er);
      end
      pop("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vproc_div_seq.md
Name: vproc_div_seq

Overview:
- Iterative, multi-cycle integer divide sequencer for one vector element lane, up to 32 bits wide.
- Accepts one dividend/divisor pair per handshake and runs a radix-2 restoring shift-subtract loop whose iteration count depends on element width.
- Handles RISC-V divide-by-zero and signed-overflow cases without iterating, applies sign fix-up, and holds the result until the downstream pipe accepts it.
- Sits between the vector DIV unit's operand buffers and its result buffer.

Parameters:
- DIV_OP_W, 32, lane operand/result width in bits; must be 32.
- CTRL_T, logic, opaque control payload carried alongside the element and returned unchanged.

Ports:
- clk_i  in  1  clock.
- async_rst_ni  in  1  asynchronous active-low reset.
- pipe_in_valid_i  in  1  input element valid.
- pipe_in_ready_o  out  1  sequencer can accept an element.
- pipe_in_ctrl_i  in  CTRL_T  control payload.
- pipe_in_eew_i  in  vsew_t  element width (VSEW_8/16/32).
- pipe_in_op_i  in  div_op_t  DIVU, DIV, REMU or REM.
- pipe_in_op1_i  in  DIV_OP_W  dividend, in the low eew bits.
- pipe_in_op2_i  in  DIV_OP_W  divisor, in the low eew bits.
- pipe_in_mask_i  in  1  element active (0 = masked).
- pipe_out_valid_o  out  1  result valid.
- pipe_out_ready_i  in  1  downstream accepts the result.
- pipe_out_ctrl_o  out  CTRL_T  payload of the returned element.
- pipe_out_res_o  out  DIV_OP_W  result, low eew bits; upper bits 0.
- pipe_out_mask_o  out  1  mask of the returned element.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; pipe_out_valid_o=0, pipe_out_res_o=0, pipe_out_mask_o=0, iteration counter=0.
  - pipe_in_ready_o=1 from the first cycle after release.
  - Reset during ITER discards the element; no partial result is ever emitted.
- FSM states: IDLE, PREP, ITER, FIXUP, DONE.
- Acceptance: pipe_in_valid_i & pipe_in_ready_o in cycle c.
  - ctrl, eew, op, mask and operands are registered.
  - State in c+1 is PREP.
- pipe_in_ready_o = (state==IDLE) | (state==DONE & pipe_out_ready_i). A new element is accepted in the same cycle the previous result leaves, with no bubble.
- PREP:
  - Set W = 8/16/32 from eew.
  - Sign-extend both operands from bit W-1 when op is DIV or REM; otherwise zero-extend.
  - Take absolute values and record the quotient sign (sign1 XOR sign2) and the remainder sign (sign1).
  - Special cases go straight to DONE (valid in c+2), each with its forced result:
    - mask=0: result 0.
    - Divisor==0: DIV/DIVU give all-ones in W bits; REM/REMU give the dividend.
    - Signed overflow (DIV/REM, dividend = most-negative W-bit value, divisor = -1): DIV gives the dividend; REM gives 0.
  - Otherwise load the counter with W-1 and go to ITER.
- ITER:
  - One quotient bit per cycle, MSB first, using 33-bit partial remainder subtract-and-restore.
  - Counter decrements each cycle; at counter 0 go to FIXUP.
  - Occupies cycles c+2 .. c+W+1.
- FIXUP (cycle c+W+2):
  - Negate the quotient or remainder according to the recorded signs.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU), truncate to W bits, zero the upper bits, go to DONE.
- DONE:
  - pipe_out_valid_o=1 and outputs held stable until pipe_out_ready_i.
  - Normal latency: valid in c+W+3, i.e. 11, 19 or 35 cycles after acceptance.
  - On handshake: go to PREP if a new element is accepted in the same cycle, else IDLE.
- Backpressure: DONE is held indefinitely; outputs must not change while valid is high and ready is low.
- pipe_in_* inputs are ignored whenever ready is low.

Decomposition:
- Shared package vproc_pkg:
  - div_op_t enum {DIV_OP_DIVU, DIV_OP_DIV, DIV_OP_REMU, DIV_OP_REM}.
  - div_seq_state_t enum.
  - vsew_t, which already exists there.
- One sub-module, vproc_div_iter_step: combinational single restoring step.
  - Inputs: partial remainder (33b), divisor (32b), next dividend bit.
  - Outputs: new remainder and quotient bit.
  - The sequencer owns all registers and the FSM.

Test Plan:
- DIVU, eew8, op1=200, op2=7, mask=1, accepted in cycle c → res=0x0000001C, valid first in c+11.
- REM, eew32, op1=0xFFFFFFF9 (-7), op2=2 → res=0xFFFFFFFF (-1), valid in c+35. DIV with the same operands → 0xFFFFFFFD (-3).
- DIV, eew16, op1=0x8000, op2=0xFFFF → res=0x00008000, valid in c+2. REM with the same operands → 0x00000000.
- DIVU, eew32, op2=0 → 0xFFFFFFFF. REMU, eew8, op1=0x5A, op2=0 → 0x0000005A. Both valid in c+2.
- Backpressure and back-to-back:
  - Hold pipe_out_ready_i=0 for 5 cycles in DONE; outputs stay stable and pipe_in_ready_o=0.
  - Raise ready with a new element pending; the result handshake and the new acceptance occur in the same cycle, and PREP is entered next.
- Reset mid-operation: assert async_rst_ni=0 during ITER → valid=0 immediately. After release, ready=1, and the next element (DIVU eew8 9/3) returns exactly 3 with no stale output.
